// File: rtl/pipe_hazard_unit.sv
// Hazard unit for a 5-stage pipeline: forwarding, load-use stall,
// branch flush, memory wait, debug halt/step and perf counters.
module pipe_hazard_unit #(
  parameter int AW         = 5,
  parameter int BR_PENALTY = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             debug_en,
  input  logic             debug_step,
  input  logic [AW-1:0]    id_rs_addr,
  input  logic [AW-1:0]    id_rt_addr,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_is_load,
  input  logic             id_is_store,
  input  logic             id_is_branch,
  input  logic [AW-1:0]    exe_rs_addr,
  input  logic [AW-1:0]    exe_rt_addr,
  input  logic [AW-1:0]    exe_waddr,
  input  logic             mem_wen,
  input  logic             mem_is_load,
  input  logic [AW-1:0]    mem_waddr,
  input  logic             wb_wen,
  input  logic [AW-1:0]    wb_waddr,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [4:0]       stage_en,
  output logic [4:0]       stage_rst,
  output logic [1:0]       dbg_state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    HALT = 2'b01,
    STEP = 2'b10
  } dbg_e;

  localparam logic [2:0] PEN_M1 = 3'(BR_PENALTY - 1);

  dbg_e             dbg_q, dbg_d;
  logic             step_prev_q;
  logic             exe_is_load_q, exe_is_load_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             load_stall;
  logic             mem_wait;

  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] a);
    if (mem_wen && mem_waddr != '0 && mem_waddr == a)
      return mem_is_load ? 2'b10 : 2'b01;
    else if (wb_wen && wb_waddr != '0 && wb_waddr == a)
      return 2'b11;
    else
      return 2'b00;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(exe_rs_addr);
    fwd_b = fwd_sel(exe_rt_addr);
  end

  assign mem_wait   = mem_req & ~mem_ready;
  assign load_stall = exe_is_load_q && exe_waddr != '0 &&
                      ((id_rs_used && id_rs_addr == exe_waddr) ||
                       (id_rt_used && !id_is_store &&
                        id_rt_addr == exe_waddr));

  // Reset drives stage_rst combinationally so it takes effect mid-cycle.
  always_comb begin
    stage_en  = 5'b11111;
    stage_rst = 5'b00000;
    fcnt_d    = fcnt_q;
    if (rst) begin
      stage_rst = 5'b11111;
    end else if (mem_wait) begin
      stage_en = 5'b00000;
    end else if (dbg_q == HALT) begin
      stage_en = 5'b00000;
    end else if (load_stall) begin
      stage_en[1:0] = 2'b00;
      stage_rst[2]  = 1'b1;
    end else if (id_is_branch) begin
      stage_rst[1] = 1'b1;
      fcnt_d       = PEN_M1;
    end else if (fcnt_q != 3'd0) begin
      stage_rst[1] = 1'b1;
      fcnt_d       = fcnt_q - 3'd1;
    end
  end

  always_comb begin
    exe_is_load_d = exe_is_load_q;
    if (stage_rst[2])
      exe_is_load_d = 1'b0;
    else if (stage_en[2])
      exe_is_load_d = id_is_load;
  end

  always_comb begin
    dbg_d = dbg_q;
    unique case (dbg_q)
      RUN:  if (debug_en) dbg_d = HALT;
      HALT: begin
        if (!debug_en)
          dbg_d = RUN;
        else if (debug_step && !step_prev_q)
          dbg_d = STEP;
      end
      STEP: dbg_d = debug_en ? HALT : RUN;
      default: dbg_d = RUN;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if ((mem_wait || load_stall) && stall_q != '1)
      stall_d = stall_q + CNT_W'(1);
    if (stage_rst[1] && flush_q != '1)
      flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_q         <= RUN;
      step_prev_q   <= 1'b0;
      exe_is_load_q <= 1'b0;
      fcnt_q        <= 3'd0;
      stall_q       <= '0;
      flush_q       <= '0;
    end else begin
      dbg_q         <= dbg_d;
      step_prev_q   <= debug_step;
      exe_is_load_q <= exe_is_load_d;
      fcnt_q        <= fcnt_d;
      stall_q       <= stall_d;
      flush_q       <= flush_d;
    end
  end

  assign dbg_state   = dbg_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: forwarding table, directed corner
// sequences and a random run against a behavioural model.
module tb_pipe_hazard_unit;

  localparam int AW    = 5;
  localparam int PEN   = 3;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          debug_en, debug_step;
  logic [AW-1:0] id_rs_addr, id_rt_addr;
  logic          id_rs_used, id_rt_used;
  logic          id_is_load, id_is_store, id_is_branch;
  logic [AW-1:0] exe_rs_addr, exe_rt_addr, exe_waddr;
  logic          mem_wen, mem_is_load;
  logic [AW-1:0] mem_waddr;
  logic          wb_wen;
  logic [AW-1:0] wb_waddr;
  logic          mem_req, mem_ready;
  logic [1:0]    fwd_a, fwd_b;
  logic [4:0]    stage_en, stage_rst;
  logic [1:0]    dbg_state;
  logic [CW-1:0] stall_count, flush_count;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_hazard_unit #(.AW(AW), .BR_PENALTY(PEN), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .debug_en(debug_en), .debug_step(debug_step),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_is_load(id_is_load), .id_is_store(id_is_store),
    .id_is_branch(id_is_branch),
    .exe_rs_addr(exe_rs_addr), .exe_rt_addr(exe_rt_addr),
    .exe_waddr(exe_waddr),
    .mem_wen(mem_wen), .mem_is_load(mem_is_load),
    .mem_waddr(mem_waddr),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stage_en(stage_en), .stage_rst(stage_rst),
    .dbg_state(dbg_state),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mw;
    logic [4:0] ma;
    logic       ml;
    logic       ww;
    logic [4:0] wa;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] ea;
    logic [1:0] eb;
  } fv_t;

  fv_t tbl[8];

  // model state
  bit m_el;
  int m_pend, m_dbg, m_sc, m_fc;
  bit m_prev;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic quiet();
    debug_en = 0; debug_step = 0;
    id_rs_addr = 0; id_rt_addr = 0;
    id_rs_used = 0; id_rt_used = 0;
    id_is_load = 0; id_is_store = 0; id_is_branch = 0;
    exe_rs_addr = 0; exe_rt_addr = 0; exe_waddr = 0;
    mem_wen = 0; mem_is_load = 0; mem_waddr = 0;
    wb_wen = 0; wb_waddr = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1;
    tick();
    rst = 0;
  endtask

  function automatic int ref_fwd(input int a);
    if (mem_wen && mem_waddr != 0 && int'(mem_waddr) == a)
      return mem_is_load ? 2 : 1;
    if (wb_wen && wb_waddr != 0 && int'(wb_waddr) == a)
      return 3;
    return 0;
  endfunction

  task automatic model_cycle();
    int ea, eb, een, ers;
    bit ls, mw;
    ea = ref_fwd(int'(exe_rs_addr));
    eb = ref_fwd(int'(exe_rt_addr));
    chk("rnd_fwd_a", fwd_a, ea);
    chk("rnd_fwd_b", fwd_b, eb);
    if (rst) begin
      m_el = 0; m_pend = 0; m_dbg = 0; m_prev = 0;
      m_sc = 0; m_fc = 0;
      chk("rnd_rst_en", stage_en, 31);
      chk("rnd_rst_rst", stage_rst, 31);
      chk("rnd_rst_dbg", dbg_state, 0);
      chk("rnd_rst_sc", stall_count, 0);
      chk("rnd_rst_fc", flush_count, 0);
      return;
    end
    chk("rnd_dbg", dbg_state, m_dbg);
    chk("rnd_stall_cnt", stall_count, m_sc);
    chk("rnd_flush_cnt", flush_count, m_fc);
    mw = mem_req && !mem_ready;
    ls = m_el && exe_waddr != 0 &&
         ((id_rs_used && id_rs_addr == exe_waddr) ||
          (id_rt_used && !id_is_store && id_rt_addr == exe_waddr));
    een = 31;
    ers = 0;
    if (mw || m_dbg == 1) begin
      een = 0;
    end else if (ls) begin
      een = 28;
      ers = 4;
    end else if (id_is_branch) begin
      ers = 2;
      m_pend = PEN - 1;
    end else if (m_pend > 0) begin
      ers = 2;
      m_pend--;
    end
    chk("rnd_stage_en", stage_en, een);
    chk("rnd_stage_rst", stage_rst, ers);
    if (ers == 4) m_el = 0;
    else if (een[2]) m_el = id_is_load;
    if ((mw || ls) && m_sc < CMAX) m_sc++;
    if (ers == 2 && m_fc < CMAX) m_fc++;
    case (m_dbg)
      0: if (debug_en) m_dbg = 1;
      1: if (!debug_en) m_dbg = 0;
         else if (debug_step && !m_prev) m_dbg = 2;
      default: m_dbg = debug_en ? 1 : 0;
    endcase
    m_prev = debug_step;
  endtask

  initial begin
    tbl[0] = '{1'b1, 5'd3, 1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 2'b01, 2'b00};
    tbl[1] = '{1'b1, 5'd3, 1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 2'b10, 2'b00};
    tbl[2] = '{1'b1, 5'd0, 1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 2'b11, 2'b00};
    tbl[3] = '{1'b0, 5'd7, 1'b0, 1'b1, 5'd7, 5'd7, 5'd7, 2'b11, 2'b11};
    tbl[4] = '{1'b1, 5'd9, 1'b0, 1'b1, 5'd4, 5'd4, 5'd9, 2'b11, 2'b01};
    tbl[5] = '{1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00};
    tbl[6] = '{1'b1, 5'd12, 1'b1, 1'b0, 5'd12, 5'd12, 5'd12, 2'b10, 2'b10};
    tbl[7] = '{1'b0, 5'd5, 1'b1, 1'b0, 5'd5, 5'd5, 5'd5, 2'b00, 2'b00};

    quiet();
    rst = 1;
    tick();
    tick();
    chk("reset_en", stage_en, 31);
    chk("reset_rst", stage_rst, 31);
    chk("reset_dbg", dbg_state, 0);
    chk("reset_sc", stall_count, 0);
    chk("reset_fc", flush_count, 0);

    // forwarding is combinational, so it is exercised while in reset
    for (int i = 0; i < 8; i++) begin
      mem_wen = tbl[i].mw; mem_waddr = tbl[i].ma;
      mem_is_load = tbl[i].ml;
      wb_wen = tbl[i].ww; wb_waddr = tbl[i].wa;
      exe_rs_addr = tbl[i].rs; exe_rt_addr = tbl[i].rt;
      #1;
      chk($sformatf("fwd_a[%0d]", i), fwd_a, tbl[i].ea);
      chk($sformatf("fwd_b[%0d]", i), fwd_b, tbl[i].eb);
    end

    // load-use stall, then async reset during a second stall
    do_reset();
    id_is_load = 1;
    #1 chk("lu_pre_en", stage_en, 31);
    tick();
    id_is_load = 0; exe_waddr = 5;
    id_rs_used = 1; id_rs_addr = 5;
    #1 chk("lu_en", stage_en, 28);
    chk("lu_rst", stage_rst, 4);
    tick();
    #1 chk("lu_cnt", stall_count, 1);
    chk("lu_clean_en", stage_en, 31);
    chk("lu_clean_rst", stage_rst, 0);
    id_is_load = 1;
    tick();
    #1 chk("lu2_en", stage_en, 28);
    #2 rst = 1;
    #1 chk("arst_rst", stage_rst, 31);
    chk("arst_en", stage_en, 31);
    chk("arst_sc", stall_count, 0);
    @(posedge clk);
    #3 rst = 0;
    #1 chk("post_rst_en", stage_en, 31);
    chk("post_rst_rst", stage_rst, 0);

    // branch flush length
    do_reset();
    id_is_branch = 1;
    #1 chk("br_c0", stage_rst, 2);
    tick();
    id_is_branch = 0;
    for (int i = 1; i < 3; i++) begin
      #1 chk($sformatf("br_c%0d", i), stage_rst, 2);
      tick();
    end
    #1 chk("br_done", stage_rst, 0);
    chk("br_fc", flush_count, 3);

    // memory wait freezes a flush in progress
    do_reset();
    id_is_branch = 1;
    tick();
    id_is_branch = 0; mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("mw_en%0d", i), stage_en, 0);
      chk($sformatf("mw_rst%0d", i), stage_rst, 0);
      tick();
    end
    mem_req = 0;
    for (int i = 0; i < 2; i++) begin
      #1 chk($sformatf("mw_resume%0d", i), stage_rst, 2);
      tick();
    end
    #1 chk("mw_done", stage_rst, 0);
    chk("mw_fc", flush_count, 3);
    chk("mw_sc", stall_count, 4);

    // debug halt and single step
    do_reset();
    debug_en = 1;
    #1 chk("dbg_run", dbg_state, 0);
    tick();
    #1 chk("dbg_halt", dbg_state, 1);
    chk("dbg_halt_en", stage_en, 0);
    debug_step = 1;
    #1 chk("dbg_pre_step", dbg_state, 1);
    tick();
    #1 chk("dbg_step", dbg_state, 2);
    chk("dbg_step_en", stage_en, 31);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("dbg_hold%0d", i), dbg_state, 1);
      chk($sformatf("dbg_hold_en%0d", i), stage_en, 0);
      tick();
    end
    debug_step = 0;
    tick();
    debug_en = 0;
    #1 chk("dbg_still", dbg_state, 1);
    tick();
    #1 chk("dbg_back", dbg_state, 0);
    chk("dbg_back_en", stage_en, 31);

    // random run against the model
    do_reset();
    m_el = 0; m_pend = 0; m_dbg = 0; m_prev = 0;
    m_sc = 0; m_fc = 0;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) debug_en = ~debug_en;
      debug_step   = ($urandom_range(0, 2) == 0);
      id_rs_addr   = AW'($urandom_range(0, 3));
      id_rt_addr   = AW'($urandom_range(0, 3));
      id_rs_used   = 1'($urandom_range(0, 1));
      id_rt_used   = 1'($urandom_range(0, 1));
      id_is_load   = ($urandom_range(0, 2) == 0);
      id_is_store  = ($urandom_range(0, 3) == 0);
      id_is_branch = ($urandom_range(0, 5) == 0);
      exe_rs_addr  = AW'($urandom_range(0, 3));
      exe_rt_addr  = AW'($urandom_range(0, 3));
      exe_waddr    = AW'($urandom_range(0, 3));
      mem_wen      = 1'($urandom_range(0, 1));
      mem_is_load  = 1'($urandom_range(0, 1));
      mem_waddr    = AW'($urandom_range(0, 3));
      wb_wen       = 1'($urandom_range(0, 1));
      wb_waddr     = AW'($urandom_range(0, 3));
      mem_req      = ($urandom_range(0, 3) == 0);
      mem_ready    = 1'($urandom_range(0, 1));
      #3;
      model_cycle();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- AW, 5, register address width.
- BR_PENALTY, 3, ID flush cycles per taken jump/branch, legal 1..4.
- CNT_W, 16, perf counter width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- debug_en  in  1  debug suspend request.
- debug_step  in  1  single-step request; rising edge is significant.
- id_rs_addr, id_rt_addr  in  AW  ID source registers.
- id_rs_used, id_rt_used, id_is_load, id_is_store, id_is_branch  in  1  ID decode flags.
- exe_rs_addr, exe_rt_addr  in  AW  EXE source registers.
- exe_waddr  in  AW  EXE destination register.
- mem_wen, mem_is_load  in  1  MEM write-back enable and load flag.
- mem_waddr  in  AW  MEM destination register.
- wb_wen  in  1  WB write-back enable.
- wb_waddr  in  AW  WB destination register.
- mem_req, mem_ready  in  1  data-memory access pending / completion handshake.
- fwd_a, fwd_b  out  2  EXE operand select: 00 regfile, 01 MEM ALU, 10 MEM load data, 11 WB.
- stage_en, stage_rst  out  5  per stage, bit0 IF .. bit4 WB.
- dbg_state  out  2  00 RUN, 01 HALT, 10 STEP.
- stall_count, flush_count  out  CNT_W  performance counters.

Function
REQ-003 Forwarding SHALL be combinational.
- fwd_a/fwd_b SHALL be 01 when mem_wen, mem_waddr!=0 and mem_waddr equals exe_rs_addr/exe_rt_addr; 10 in that case if mem_is_load.
- Otherwise 11 when wb_wen, wb_waddr!=0 and the addresses match; otherwise 00.
- MEM SHALL have priority over WB.
REQ-004 Register exe_is_load SHALL capture id_is_load when stage_en[2]=1 and stage_rst[2]=0; it SHALL clear when stage_rst[2]=1; otherwise it SHALL hold.
REQ-005 load_stall SHALL assert when exe_is_load and either condition holds:
- id_rs_used and id_rs_addr==exe_waddr.
- id_rt_used, !id_is_store and id_rt_addr==exe_waddr.
- exe_waddr==0 SHALL never stall.
REQ-006 mem_wait SHALL equal mem_req & ~mem_ready.
REQ-007 Flush counter fcnt (3 bits): a branch in ID SHALL load fcnt with BR_PENALTY-1 and assert stage_rst[1] that cycle, unless a higher-priority condition holds. While fcnt>0 and no higher-priority condition holds: assert stage_rst[1], decrement fcnt. Total flush cycles SHALL be exactly BR_PENALTY.
REQ-008 Debug FSM:
- RUN->HALT when debug_en=1.
- HALT->STEP on a debug_step 0->1 edge, detected with a registered previous value.
- STEP->HALT after exactly one cycle.
- HALT/STEP->RUN when debug_en=0.
REQ-009 Stage control SHALL default to stage_en=11111, stage_rst=00000, with priority, highest first:
- mem_wait: stage_en=00000; fcnt holds.
- dbg_state==HALT: stage_en=00000; fcnt holds.
- load_stall: stage_en[1:0]=00, stage_rst[2]=1; fcnt holds.
- branch/flush per REQ-007.
- STEP SHALL apply the normal rules below HALT.
REQ-010 stall_count SHALL increment on each cycle with mem_wait or load_stall. flush_count SHALL increment on each cycle with stage_rst[1]=1 outside reset. Both SHALL saturate at all-ones.
REQ-011 A branch in ID while fcnt>0 SHALL reload fcnt with BR_PENALTY-1.

Reset
REQ-012 While rst=1:
- stage_rst=11111, stage_en=11111.
- fcnt=0, exe_is_load=0, dbg_state=RUN, debug_step history=0, both counters=0.
- fwd_a/fwd_b remain combinational.
REQ-013 Reset asserted mid-flush or mid-stall SHALL abort it immediately; the first cycle after release SHALL have no flush or stall unless inputs demand one.

Verification
REQ-014 Forwarding: mem_wen=1, mem_waddr=3, exe_rs_addr=3, wb_wen=1, wb_waddr=3 -> fwd_a=01. Set mem_is_load=1 -> 10. Set mem_waddr=0 -> 11.
REQ-015 Load-use: lw to r5 advances to EXE; next ID uses rs=5 -> one cycle with stage_en=11100, stage_rst[2]=1, stall_count=1; the following cycle is clean.
REQ-016 Branch, BR_PENALTY=3: id_is_branch for one cycle -> stage_rst[1]=1 for exactly 3 consecutive cycles, flush_count=3.
REQ-017 Memory wait: mem_req=1, mem_ready=0 for 4 cycles during a flush with fcnt=2 -> stage_en=00000 for 4 cycles, fcnt stays 2, and the flush resumes afterwards.
REQ-018 Debug: debug_en=1 -> HALT and stage_en=00000. One debug_step pulse -> exactly one STEP cycle with stage_en=11111. debug_step held high -> no further step.
REQ-019 Reset: rst asserted asynchronously mid-clock during a load stall -> outputs take reset values immediately, without waiting for a clock edge.
